// File: rtl/initval_arb_pkg.sv
// initval_arb_pkg
//   Shared types and helpers for the initval_arb round-robin arbiter.
//   - state_t        : arbiter FSM states (two-bit encoding)
//   - LAST_SEL_INIT  : value of last_sel out of reset / power-on, so that
//                      requester 0 wins the first contest
//   - rr_win()       : two-way round-robin winner selection
package initval_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic LAST_SEL_INIT = 1'b1;

  // A lone requester always wins; on a tie the requester that did not
  // win last time gets the grant.
  function automatic logic rr_win(input logic [1:0] req, input logic last_sel);
    if (req == 2'b11) begin
      return ~last_sel;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/initval_arb_pick.sv
// rr_pick2
//   Combinational two-way round-robin picker.
//   Ports:
//     req      in  2  request vector
//     last_sel in  1  index of the previous winner
//     win      out 1  index of the winner (meaningful when valid)
//     valid    out 1  at least one request present
module rr_pick2
  import initval_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_sel,
  output logic       win,
  output logic       valid
);

  assign win   = rr_win(req, last_sel);
  assign valid = |req;

endmodule

// File: rtl/initval_arb.sv
// initval_arb
//   Two-requester round-robin arbiter owning the shared result register foo.
//   The upper half of foo is registered from the granted requester's data on
//   every GRANT cycle; the lower half is a combinational pass-through of the
//   granted data and reads zero whenever no grant is active.
//   Every grant is followed by one RELEASE cycle, so grants are never
//   back-to-back. State registers carry declared initial values equal to
//   their reset values, making power-on and post-reset behaviour identical.
//   Ports:
//     clk      in  1  clock, all state updates on posedge
//     rst      in  1  synchronous reset, active-high
//     req      in  2  level request per requester
//     data0    in  W  requester 0 data
//     data1    in  W  requester 1 data
//     gnt      out 2  one-hot grant (registered)
//     busy     out 1  high whenever the arbiter is not IDLE
//     last_sel out 1  index of the most recent grant winner
//     foo      out W  shared result: [W-1:H] registered, [H-1:0] combinational
module initval_arb
  import initval_arb_pkg::*;
#(
  parameter int W    = 4,
  parameter int HOLD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         last_sel,
  output logic [W-1:0] foo
);

  localparam int H     = W / 2;
  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q = IDLE;
  logic [1:0]       gnt_q   = 2'b00;
  logic [CNT_W-1:0] cnt_q   = '0;
  logic             last_q  = LAST_SEL_INIT;
  logic [W-1:H]     hi_q    = '0;

  state_t           state_d;
  logic [1:0]       gnt_d;
  logic [CNT_W-1:0] cnt_d;
  logic             last_d;
  logic [W-1:H]     hi_d;

  logic             win;
  logic             valid;
  logic [W-1:0]     data_sel;
  logic             gnt_req;

  rr_pick2 u_pick (
    .req      (req),
    .last_sel (last_q),
    .win      (win),
    .valid    (valid)
  );

  assign data_sel = gnt_q[1] ? data1 : data0;
  // Granted requester is still asking for the bus.
  assign gnt_req  = |(gnt_q & req);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    hi_d    = hi_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = GRANT;
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          cnt_d   = CNT_LOAD;
        end
      end
      GRANT: begin
        hi_d = data_sel[W-1:H];
        if ((cnt_q == '0) || !gnt_req) begin
          state_d = RELEASE;
          gnt_d   = 2'b00;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
      last_q  <= LAST_SEL_INIT;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      hi_q    <= hi_d;
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != IDLE);
    gnt      = gnt_q;
    last_sel = last_q;
    foo      = {hi_q, (gnt_q != 2'b00) ? data_sel[H-1:0] : {H{1'b0}}};
  end

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt_q));
  a_lo_zero:    assert property (@(posedge clk) (gnt_q == 2'b00) |-> (foo[H-1:0] == {H{1'b0}}));
  a_lo_pass:    assert property (@(posedge clk) (state_q == GRANT) |-> (foo[H-1:0] == data_sel[H-1:0]));
  a_busy:       assert property (@(posedge clk) busy == (state_q != IDLE));

endmodule

// File: tb/tb_initval_arb.sv
module tb_initval_arb;

  localparam int W    = 4;
  localparam int HOLD = 2;
  localparam int H    = W / 2;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic [1:0]   req   = 2'b00;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic [1:0]   gnt;
  logic         busy;
  logic         last_sel;
  logic [W-1:0] foo;

  initval_arb #(.W(W), .HOLD(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .gnt      (gnt),
    .busy     (busy),
    .last_sel (last_sel),
    .foo      (foo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how long it has owned it, whether
  // the mandatory dead cycle is pending, the last winner and the captured
  // upper half of foo.
  int           m_owner = -1;
  int           m_len   = 0;
  bit           m_dead  = 1'b0;
  bit           m_last  = 1'b1;
  logic [W-1:H] m_hi    = '0;
  int           run_len = 0;

  typedef struct {
    logic         r;
    logic [1:0]   q;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   g;
    logic         bz;
    logic         ls;
    logic [W-1:0] f;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    logic [W-1:0] d;
    if (rst) begin
      m_owner = -1; m_len = 0; m_dead = 1'b0; m_last = 1'b1; m_hi = '0;
    end else if (m_owner >= 0) begin
      d = (m_owner == 1) ? data1 : data0;
      m_hi = d[W-1:H];
      m_len++;
      if (m_len == HOLD || !req[m_owner]) begin
        m_owner = -1;
        m_dead  = 1'b1;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (req != 2'b00) begin
      m_owner = (req == 2'b11) ? int'(!m_last) : int'(req[1]);
      m_last  = (m_owner == 1);
      m_len   = 0;
    end
  endtask

  function automatic logic [1:0] e_gnt();
    if (m_owner < 0) return 2'b00;
    return (m_owner == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [W-1:0] e_foo();
    logic [W-1:0] d;
    d = (m_owner == 1) ? data1 : data0;
    return {m_hi, (m_owner < 0) ? {H{1'b0}} : d[H-1:0]};
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".gnt"}, gnt, e_gnt());
    chk({tag, ".busy"}, busy, (m_owner >= 0) || m_dead);
    chk({tag, ".last_sel"}, last_sel, m_last);
    chk({tag, ".foo"}, foo, e_foo());
  endtask

  task automatic step(input logic r, input logic [1:0] q, input logic [W-1:0] a, input logic [W-1:0] b);
    rst = r; req = q; data0 = a; data1 = b;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_const(input string tag, input logic [1:0] g, input logic bz,
                             input logic ls, input logic [W-1:0] f);
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".busy"}, busy, bz);
    chk({tag, ".last_sel"}, last_sel, ls);
    chk({tag, ".foo"}, foo, f);
  endtask

  initial begin
    // req held at 11 with data0=A, data1=5, starting from IDLE, last_sel=1
    vecs[0] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b01, 1'b1, 1'b0, 4'h2};
    vecs[1] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b01, 1'b1, 1'b0, 4'hA};
    vecs[2] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b00, 1'b1, 1'b0, 4'h8};
    vecs[3] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b00, 1'b0, 1'b0, 4'h8};
    vecs[4] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b10, 1'b1, 1'b1, 4'h9};
    vecs[5] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b10, 1'b1, 1'b1, 4'h5};
    vecs[6] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b00, 1'b1, 1'b1, 4'h4};
    vecs[7] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b00, 1'b0, 1'b1, 4'h4};
    vecs[8] = '{1'b0, 2'b11, 4'hA, 4'h5, 2'b01, 1'b1, 1'b0, 4'h6};

    // Power-on state without any reset
    #1;
    check_const("poweron", 2'b00, 1'b0, 1'b1, 4'h0);
    check_model("poweron_model");

    step(1'b1, 2'b00, 4'h0, 4'h0);
    check_const("reset", 2'b00, 1'b0, 1'b1, 4'h0);

    // Alternation under continuous requests
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].r, vecs[i].q, vecs[i].a, vecs[i].b);
      check_const($sformatf("alt%0d", i), vecs[i].g, vecs[i].bz, vecs[i].ls, vecs[i].f);
      check_model($sformatf("alt%0d_model", i));
    end

    // Lower half follows data the same cycle, upper half one edge later
    step(1'b1, 2'b00, 4'h0, 4'h0);
    step(1'b0, 2'b01, 4'h3, 4'h0);
    check_const("track_g1", 2'b01, 1'b1, 1'b0, 4'h3);
    data0 = 4'hC;
    #1;
    chk("track_comb.foo", foo, 4'h0);
    check_model("track_comb_model");
    step(1'b0, 2'b01, 4'hC, 4'h0);
    check_const("track_g2", 2'b01, 1'b1, 1'b0, 4'hC);
    step(1'b0, 2'b00, 4'hC, 4'h0);
    check_const("track_rel", 2'b00, 1'b1, 1'b0, 4'hC);

    // Request dropped after the first grant cycle ends the grant early
    step(1'b1, 2'b00, 4'h0, 4'h0);
    step(1'b0, 2'b01, 4'h6, 4'h0);
    check_const("drop_g", 2'b01, 1'b1, 1'b0, 4'h2);
    step(1'b0, 2'b00, 4'h6, 4'h0);
    check_const("drop_rel", 2'b00, 1'b1, 1'b0, 4'h4);
    step(1'b0, 2'b00, 4'h6, 4'h0);
    check_const("drop_idle", 2'b00, 1'b0, 1'b0, 4'h4);

    // Reset during the second grant cycle
    step(1'b1, 2'b00, 4'h0, 4'h0);
    step(1'b0, 2'b01, 4'hF, 4'h0);
    check_const("rstmid_g1", 2'b01, 1'b1, 1'b0, 4'h3);
    step(1'b1, 2'b01, 4'hF, 4'h0);
    check_const("rstmid_rst", 2'b00, 1'b0, 1'b1, 4'h0);
    step(1'b0, 2'b00, 4'hF, 4'h0);
    check_const("rstmid_idle", 2'b00, 1'b0, 1'b1, 4'h0);

    // Randomized traffic against the model
    step(1'b1, 2'b00, 4'h0, 4'h0);
    run_len = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), 2'($urandom), W'($urandom), W'($urandom));
      check_model("rand");
      if (gnt != 2'b00) begin
        run_len++;
        chk("rand.grant_len_over_hold", int'(run_len > HOLD), 0);
      end else begin
        run_len = 0;
      end
      if ($urandom_range(0, 3) == 0) begin
        data0 = W'($urandom);
        data1 = W'($urandom);
        #1;
        chk("rand_comb.foo", foo, e_foo());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
